picorv32_mem_responder: RTL and testbench
=========================================

# picorv32_mem_responder

Memory-side responder for the picorv32 native memory interface: accepts `mem_valid` requests from the core, inserts a bounded number of wait states, services word reads and byte-lane writes against an internal word array, and completes each transfer with a single-cycle `mem_ready` pulse. It sits opposite the core in simulation and formal benches, replacing free `mem_ready`/`mem_rdata` inputs with a deterministic, protocol-checking memory. Protocol violations and out-of-range accesses are flagged on dedicated outputs.

## Interface
- `MEM_WORDS`, 256: number of 32-bit words; valid word index `mem_addr[31:2] < MEM_WORDS`.
- `WAIT_CYCLES`, 2: fixed wait states per transfer (0..15).
- `MAX_WAIT`, 4: upper bound on wait states in LFSR mode (0..15).

- `clk`  in  1  clock; all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `mem_valid`  in  1  request valid from core.
- `mem_instr`  in  1  request is instruction fetch (captured, informational only).
- `mem_addr`  in  32  byte address; bits [1:0] ignored.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte write enables; 0 = read.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  32  read data, valid while `mem_ready`=1.
- `range_err`  out  1  one-cycle pulse with `mem_ready` when the address is out of range.
- `proto_err`  out  1  sticky: the request changed or dropped before completion.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: on `mem_valid`=1, capture addr/wdata/wstrb/instr, load `wait_cnt` with the wait count W, go to WAIT if W>0, else RESP.
- WAIT: decrement `wait_cnt`; at 1 go to RESP. Every cycle, compare live `mem_valid`/`mem_addr`/`mem_wdata`/`mem_wstrb` against captured values; any mismatch or `mem_valid`=0 sets `proto_err`. The transfer still completes using captured values.
- RESP: `mem_ready`=1 for exactly this cycle; the same check as WAIT applies. Then go to IDLE unconditionally.
- Read (`wstrb`=0): `mem_rdata` = array[word index], registered so it is valid in the RESP cycle.
- Write: in the RESP cycle, update lanes i with `wstrb[i]`=1 (byte i = `wdata[8i+7:8i]`). `mem_rdata`=0 during a write response.
- Out of range: reads return 0, writes are dropped, and `range_err` pulses in the RESP cycle.
- Back-to-back: the cycle after RESP is IDLE, so a new request is accepted then (including one where `mem_valid` never dropped).
- `wait_cnt` is 4 bits wide; W values above 15 are not legal configurations.

## Timing
- Request first sampled in IDLE at cycle T, then `mem_ready`=1 at cycle T+1+W. Minimum W=0 gives `mem_ready` at T+1.
- Throughput: one transfer per W+2 cycles.
- `mem_ready` is never high on two consecutive cycles.
- Reset values: state IDLE, `mem_ready`=0, `mem_rdata`=0, `range_err`=0, `proto_err`=0, `wait_cnt`=0. Array contents are not reset.
- Reset asserted mid-transfer (WAIT or RESP): the transfer is abandoned, no write is applied, and the next cycle is IDLE with all outputs at reset values.
- `mem_valid` while in WAIT/RESP is never treated as a new request.

## Configuration
- `MEM_RESP_LFSR_WAIT_EN` defined:
  - W = `lfsr[3:0]` mod (`MAX_WAIT`+1).
  - `lfsr` is a 16-bit Fibonacci LFSR with taps 16,14,13,11, seeded 16'hACE1 on reset.
  - The LFSR advances once per accepted request (IDLE to WAIT/RESP).
- Not defined: W = `WAIT_CYCLES` for every transfer and no LFSR is instantiated.

## Test plan
- Write then read: write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF, W=2.
  - Required: `mem_ready` at T+3; a later read of 0x10 returns 0xDEADBEEF.
- Byte lanes: preload 0x11223344 at 0x20, write wdata 0xAABBCCDD with wstrb 4'b0101.
  - Required: a read of 0x20 returns 0x11BB33DD.
- Range: with `MEM_WORDS`=256, read addr 0x400.
  - Required: `mem_rdata`=0 and `range_err`=1 in the `mem_ready` cycle.
  - Required: a write to 0x400 leaves all words unchanged.
- Protocol: change `mem_addr` from 0x8 to 0xC during WAIT.
  - Required: `proto_err`=1 from the next cycle until reset; the read returns word 0x8.
- Reset mid-transfer: write to 0x30 and drop `resetn` for 1 cycle in WAIT.
  - Required: no `mem_ready`, word 0x30 unchanged, and a new request is accepted on the first cycle after reset.
- Back-to-back, W=0, `mem_valid` held high across two requests.
  - Required: `mem_ready` at T+1 and T+3, never on consecutive cycles.
  - LFSR build: W is always ≤ `MAX_WAIT` over 1000 requests.

Source files
------------

// File: rtl/picorv32_mem_responder_if.sv
// picorv32 native memory bus as seen between the core (master) and the responder (slave).
interface picorv32_mem_responder_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        range_err;
    logic        proto_err;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata, range_err, proto_err
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata, range_err, proto_err
    );
endinterface

// File: rtl/picorv32_mem_responder.sv
// Deterministic wait-state memory responder for the picorv32 native bus, with protocol/range flags.
// Optional MEM_RESP_LFSR_WAIT_EN: per-transfer wait count drawn from a 16-bit LFSR, bounded by MAX_WAIT.
module picorv32_mem_responder #(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int MAX_WAIT    = 4
) (
    input logic                     clk,
    input logic                     resetn,
    picorv32_mem_responder_if.slave mem
);
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    // state  | meaning
    // S_IDLE | waiting for mem_valid; captures the request
    // S_WAIT | counting down wait states, checking request stability
    // S_RESP | mem_ready pulse; write lanes commit at the end of this cycle
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_load;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;
    logic        cap_instr;
    logic        cap_in_range;
    logic [31:0] rdata_q;
    logic        proto_q;
    logic [31:0] mem_array [MEM_WORDS];

    logic        accept;
    logic        live_in_range;
    logic        mismatch;
    logic [31:0] eff_addr;
    logic [3:0]  eff_wstrb;
    logic        eff_in_range;

    assign accept        = (state == S_IDLE) && mem.mem_valid;
    assign live_in_range = mem.mem_addr[31:2] < 30'(MEM_WORDS);
    assign mismatch      = !mem.mem_valid || (mem.mem_addr != cap_addr) ||
                           (mem.mem_wdata != cap_wdata) || (mem.mem_wstrb != cap_wstrb);

    // With zero wait states the read happens on the accepting edge, before capture.
    assign eff_addr     = (state == S_IDLE) ? mem.mem_addr  : cap_addr;
    assign eff_wstrb    = (state == S_IDLE) ? mem.mem_wstrb : cap_wstrb;
    assign eff_in_range = (state == S_IDLE) ? live_in_range : cap_in_range;

`ifdef MEM_RESP_LFSR_WAIT_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign wait_load = 4'({1'b0, lfsr[3:0]} % 5'(MAX_WAIT + 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr <= 16'hACE1;
        end else if (accept) begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end
`else
    assign wait_load = 4'(WAIT_CYCLES);
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (mem.mem_valid) state_nx = (wait_load != 4'd0) ? S_WAIT : S_RESP;
            S_WAIT: if (wait_cnt == 4'd1) state_nx = S_RESP;
            S_RESP: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        mem.mem_ready = (state == S_RESP);
        mem.range_err = (state == S_RESP) && !cap_in_range;
        mem.mem_rdata = rdata_q;
        mem.proto_err = proto_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wait_cnt     <= 4'd0;
            cap_addr     <= 32'd0;
            cap_wdata    <= 32'd0;
            cap_wstrb    <= 4'd0;
            cap_instr    <= 1'b0;
            cap_in_range <= 1'b0;
            rdata_q      <= 32'd0;
            proto_q      <= 1'b0;
        end else begin
            if (accept) begin
                wait_cnt     <= wait_load;
                cap_addr     <= mem.mem_addr;
                cap_wdata    <= mem.mem_wdata;
                cap_wstrb    <= mem.mem_wstrb;
                cap_instr    <= mem.mem_instr;
                cap_in_range <= live_in_range;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if ((state_nx == S_RESP) && (eff_wstrb == 4'd0) && eff_in_range) begin
                rdata_q <= mem_array[eff_addr[IDX_W+1:2]];
            end else begin
                rdata_q <= 32'd0;
            end

            if ((state == S_WAIT || state == S_RESP) && mismatch) begin
                proto_q <= 1'b1;
            end
        end
    end

    // Array is not reset; a reset during RESP suppresses the commit.
    always_ff @(posedge clk) begin
        if (resetn && (state == S_RESP) && cap_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_wstrb[i]) begin
                    mem_array[cap_addr[IDX_W+1:2]][8*i +: 8] <= cap_wdata[8*i +: 8];
                end
            end
        end
    end

    logic unused_instr;
    assign unused_instr = cap_instr;
endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Self-checking bench: random and directed transfers against a word-array reference model.
module tb_picorv32_mem_responder;
    localparam int MEM_WORDS   = 256;
    localparam int WAIT_CYCLES = 2;
    localparam int MAX_WAIT    = 4;
`ifdef MEM_RESP_LFSR_WAIT_EN
    localparam int N_RAND = 1000;
`else
    localparam int N_RAND = 60;
`endif

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    picorv32_mem_responder_if bus ();
    picorv32_mem_responder_if bus0 ();

    picorv32_mem_responder #(
        .MEM_WORDS(MEM_WORDS), .WAIT_CYCLES(WAIT_CYCLES), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .resetn(resetn), .mem(bus)
    );

    picorv32_mem_responder #(
        .MEM_WORDS(MEM_WORDS), .WAIT_CYCLES(0), .MAX_WAIT(MAX_WAIT)
    ) dut0 (
        .clk(clk), .resetn(resetn), .mem(bus0)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] ref_mem [MEM_WORDS];
    logic        exp_proto = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transfer on the main DUT, checked against the reference model.
    task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output logic [31:0] rd);
        int          lat;
        logic        in_range;
        logic [31:0] exp_rd;
        int          idx;
        in_range = (addr[31:2] < 30'(MEM_WORDS));
        idx      = int'(addr[9:2]);
        exp_rd   = (wstrb == 4'd0 && in_range) ? ref_mem[idx] : 32'd0;
        bus.mem_valid = 1'b1;
        bus.mem_instr = 1'($urandom_range(0, 1));
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        lat = -1;
        for (int k = 0; k <= MAX_WAIT + WAIT_CYCLES + 2; k++) begin
            @(posedge clk); #1;
            if (bus.mem_ready === 1'b1) begin
                lat = k;
                break;
            end
        end
        rd = bus.mem_rdata;
`ifdef MEM_RESP_LFSR_WAIT_EN
        chk("wait_bound", 32'((lat >= 0) && (lat <= MAX_WAIT)), 32'd1);
`else
        chk("latency", 32'(lat), 32'(WAIT_CYCLES));
`endif
        chk("rdata", bus.mem_rdata, exp_rd);
        chk("range_err", 32'(bus.range_err), 32'(!in_range));
        if (wstrb != 4'd0 && in_range) begin
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) ref_mem[idx][8*i +: 8] = wdata[8*i +: 8];
        end
        @(posedge clk); #1;
        chk("ready_not_consec", 32'(bus.mem_ready), 32'd0);
        chk("proto_err", 32'(bus.proto_err), 32'(exp_proto));
        bus.mem_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] old;

        resetn = 1'b0;
        bus.mem_valid = 1'b0; bus.mem_instr = 1'b0; bus.mem_addr = '0;
        bus.mem_wdata = '0;   bus.mem_wstrb = '0;
        bus0.mem_valid = 1'b0; bus0.mem_instr = 1'b0; bus0.mem_addr = '0;
        bus0.mem_wdata = '0;   bus0.mem_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.mem_ready), 32'd0);
        chk("rst_rdata", bus.mem_rdata, 32'd0);
        chk("rst_range", 32'(bus.range_err), 32'd0);
        chk("rst_proto", 32'(bus.proto_err), 32'd0);
        resetn = 1'b1;

        for (int w = 0; w < MEM_WORDS; w++) xfer(32'(w) << 2, $urandom, 4'hF, rd);

        xfer(32'h10, 32'hDEADBEEF, 4'hF, rd);
        xfer(32'h10, 32'h0, 4'h0, rd);
        chk("wr_rd_0x10", rd, 32'hDEADBEEF);

        xfer(32'h20, 32'h11223344, 4'hF, rd);
        xfer(32'h20, 32'hAABBCCDD, 4'b0101, rd);
        xfer(32'h20, 32'h0, 4'h0, rd);
        chk("byte_lanes", rd, 32'h11BB33DD);

        xfer(32'h400, 32'h0, 4'h0, rd);
        chk("range_rd_zero", rd, 32'd0);
        xfer(32'h400, $urandom, 4'hF, rd);
        for (int w = 0; w < MEM_WORDS; w++) xfer(32'(w) << 2, 32'h0, 4'h0, rd);

        for (int n = 0; n < N_RAND; n++) begin
            case ($urandom_range(0, 7))
                0:       a = 32'($urandom_range(MEM_WORDS, 4095)) << 2;
                1:       a = $urandom | 32'h8000_0000;
                default: a = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            xfer(a, $urandom, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), rd);
        end

`ifndef MEM_RESP_LFSR_WAIT_EN
        // Request address changes during WAIT; completion uses the captured address.
        bus.mem_valid = 1'b1; bus.mem_addr = 32'h8; bus.mem_wstrb = 4'h0; bus.mem_wdata = 32'h0;
        @(posedge clk); #1;
        chk("proto_before", 32'(bus.proto_err), 32'd0);
        bus.mem_addr = 32'hC;
        @(posedge clk); #1;
        chk("proto_set", 32'(bus.proto_err), 32'd1);
        chk("proto_wait_ready", 32'(bus.mem_ready), 32'd0);
        @(posedge clk); #1;
        chk("proto_resp_ready", 32'(bus.mem_ready), 32'd1);
        chk("proto_rdata", bus.mem_rdata, ref_mem[2]);
        @(posedge clk); #1;
        bus.mem_valid = 1'b0;
        chk("proto_ready_low", 32'(bus.mem_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("proto_sticky", 32'(bus.proto_err), 32'd1);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        chk("proto_cleared", 32'(bus.proto_err), 32'd0);

        // Reset pulse in WAIT abandons a write to 0x30.
        old = ref_mem[12];
        bus.mem_valid = 1'b1; bus.mem_addr = 32'h30; bus.mem_wdata = ~old; bus.mem_wstrb = 4'hF;
        @(posedge clk); #1;
        chk("rst_mid_wait", 32'(bus.mem_ready), 32'd0);
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_ready", 32'(bus.mem_ready), 32'd0);
        chk("rst_mid_rdata", bus.mem_rdata, 32'd0);
        chk("rst_mid_range", 32'(bus.range_err), 32'd0);
        resetn = 1'b1;
        xfer(32'h30, 32'h0, 4'h0, rd);
        chk("rst_mid_unchanged", rd, old);

        // Back-to-back with zero wait states and mem_valid held high.
        bus0.mem_valid = 1'b1; bus0.mem_addr = 32'h40; bus0.mem_wstrb = 4'h0; bus0.mem_wdata = 32'h0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("b2b_ready", 32'(bus0.mem_ready), 32'((k % 2) == 0));
        end
        bus0.mem_valid = 1'b0;
        chk("b2b_range", 32'(bus0.range_err), 32'd0);
        chk("b2b_proto", 32'(bus0.proto_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
